// File: rtl/tm_program_feeder_if.sv
// Script ROM read bus plus the three entry strobes driven into the Turing machine.
// The feeder takes the master side; ROM and machine (or a bench) take the slave side.
interface tm_program_feeder_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [5:0]        data_out;
  logic              next_out;
  logic              done_out;

  modport master (output rom_addr, data_out, next_out, done_out, input rom_data);
  modport slave  (input rom_addr, data_out, next_out, done_out, output rom_data);
endinterface

// File: rtl/tm_program_feeder.sv
// Replays a ROM command script as timed input_data / Next / Done waveforms.
// Optional halt-on-compute_done for STEP commands is enabled by defining TM_FEED_HALT_EN.
module tm_program_feeder #(
  parameter int ADDR_W    = 8,
  parameter int SETUP_CYC = 3,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
`ifdef TM_FEED_HALT_EN
  input  logic              compute_done,
`endif
  tm_program_feeder_if.master bus,
  output logic              busy,
  output logic              finished,
  output logic              overrun,
  output logic [ADDR_W-1:0] cmd_count
);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, SETUP, PULSE, GAP, STOP} state_t;
  typedef enum logic [1:0] {OP_DATA, OP_DONE, OP_STEP, OP_END} op_t;
  typedef struct packed {
    op_t        op;
    logic [5:0] payload;
  } cmd_t;

  state_t      state;
  logic [15:0] cnt;
  cmd_t        cmd;

  assign cmd = bus.rom_data;

  // Each timed state loads cnt with (length-1) on entry and leaves when it hits 0.
  // busy/finished are settled on the edge entering STOP, so STOP itself only
  // spends one cycle refusing start before IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bus.rom_addr <= '0;
      bus.data_out <= '0;
      bus.next_out <= 1'b0;
      bus.done_out <= 1'b0;
      busy         <= 1'b0;
      finished     <= 1'b0;
      overrun      <= 1'b0;
      cmd_count    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          bus.rom_addr <= '0;
          cmd_count    <= '0;
          finished     <= 1'b0;
          overrun      <= 1'b0;
          busy         <= 1'b1;
          state        <= FETCH;
        end
        FETCH: state <= LATCH;
        LATCH: begin
          case (cmd.op)
            OP_DATA: begin
              bus.data_out <= cmd.payload;
              cnt          <= 16'(SETUP_CYC - 1);
              state        <= SETUP;
            end
            OP_DONE: begin
              bus.done_out <= 1'b1;
              cnt          <= 16'(PULSE_CYC - 1);
              state        <= PULSE;
            end
            OP_STEP: begin
`ifdef TM_FEED_HALT_EN
              if (compute_done) begin
                finished <= 1'b1;
                busy     <= 1'b0;
                state    <= STOP;
              end else begin
                bus.next_out <= 1'b1;
                cnt          <= 16'(PULSE_CYC - 1);
                state        <= PULSE;
              end
`else
              bus.next_out <= 1'b1;
              cnt          <= 16'(PULSE_CYC - 1);
              state        <= PULSE;
`endif
            end
            default: begin
              finished <= 1'b1;
              busy     <= 1'b0;
              state    <= STOP;
            end
          endcase
        end
        SETUP: begin
          if (cnt == '0) begin
            bus.next_out <= 1'b1;
            cnt          <= 16'(PULSE_CYC - 1);
            state        <= PULSE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            bus.next_out <= 1'b0;
            bus.done_out <= 1'b0;
            cmd_count    <= cmd_count + 1'b1;
            cnt          <= 16'(GAP_CYC - 1);
            state        <= GAP;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 16'd1;
          end else if (&bus.rom_addr) begin
            // Ran off the last ROM word without an END command.
            overrun <= 1'b1;
            busy    <= 1'b0;
            state   <= STOP;
          end else begin
            bus.rom_addr <= bus.rom_addr + 1'b1;
            state        <= FETCH;
          end
        end
        STOP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tm_program_feeder.sv
// Bench for tm_program_feeder: scripted and random ROM programs checked against a
// command-level model of the emitted pulses, run length and status flags.
module tb_tm_program_feeder;
  localparam int AW = 8, AWS = 3, SC = 3, PC = 2, GC = 2;

  logic clock = 1'b0, reset = 1'b1, start = 1'b0, start_s = 1'b0;
  logic busy, finished, overrun, busy_s, finished_s, overrun_s;
  logic [AW-1:0]  cmd_count;
  logic [AWS-1:0] cmd_count_s;
`ifdef TM_FEED_HALT_EN
  logic compute_done = 1'b0, compute_done_s = 1'b0;
`endif

  tm_program_feeder_if #(.ADDR_W(AW))  bus ();
  tm_program_feeder_if #(.ADDR_W(AWS)) bus_s ();

  logic [7:0] rom [256];
  logic [7:0] rom_s [8];

  int vecs = 0, errs = 0;

  // command-level model state and observed/expected pulse lists
  logic [5:0] mdata = '0;
  bit         exp_done[$], obs_done[$];
  logic [5:0] exp_data[$], obs_data[$];
  int         obs_w[$];

  tm_program_feeder #(.ADDR_W(AW), .SETUP_CYC(SC), .PULSE_CYC(PC), .GAP_CYC(GC)) dut (
    .clock(clock), .reset(reset), .start(start),
`ifdef TM_FEED_HALT_EN
    .compute_done(compute_done),
`endif
    .bus(bus), .busy(busy), .finished(finished), .overrun(overrun), .cmd_count(cmd_count));

  tm_program_feeder #(.ADDR_W(AWS), .SETUP_CYC(SC), .PULSE_CYC(PC), .GAP_CYC(GC)) dut_s (
    .clock(clock), .reset(reset), .start(start_s),
`ifdef TM_FEED_HALT_EN
    .compute_done(compute_done_s),
`endif
    .bus(bus_s), .busy(busy_s), .finished(finished_s), .overrun(overrun_s),
    .cmd_count(cmd_count_s));

  always #5 clock = ~clock;
  always @(posedge clock) bus.rom_data   <= rom[bus.rom_addr];
  always @(posedge clock) bus_s.rom_data <= rom_s[bus_s.rom_addr];

  // Walks the script word by word: what each command emits and what it costs in cycles.
  task automatic model_main(output int cyc, output bit fin, output bit ovr, output int cmds);
    logic [1:0] op;
    exp_done.delete(); exp_data.delete();
    cyc = 0; fin = 0; ovr = 1; cmds = 0;
    for (int a = 0; a < 256; a++) begin
      op = rom[a][7:6];
      if (op == 2'b11) begin
        fin = 1; ovr = 0; cyc += 2;
        break;
      end
      if (op == 2'b00) begin
        mdata = rom[a][5:0];
        cyc += 2 + SC + PC + GC;
      end else begin
        cyc += 2 + PC + GC;
      end
      exp_done.push_back(op == 2'b01);
      exp_data.push_back(mdata);
      cmds++;
    end
  endtask

  // Pulses start, then watches strobes every negedge until busy drops.
  task automatic run_main(input bit spam, output int cyc, output bit to);
    bit pn, pd;
    obs_done.delete(); obs_data.delete(); obs_w.delete();
    cyc = 0; to = 1; pn = 0; pd = 0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); if (!spam) start = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (bus.next_out && bus.done_out) begin
        errs++;
        $display("FAIL strobe_overlap: next_out=1 done_out=1, required at most one high");
      end
      if ((bus.next_out && !pn) || (bus.done_out && !pd)) begin
        obs_done.push_back(bus.done_out);
        obs_data.push_back(bus.data_out);
        obs_w.push_back(0);
      end
      if (bus.next_out || bus.done_out) obs_w[obs_w.size()-1] += 1;
      pn = bus.next_out; pd = bus.done_out;
      if (!busy) begin to = 0; break; end
      cyc++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    #1;
    vecs++;
    if ({bus.rom_addr, bus.data_out, bus.next_out, bus.done_out, busy, finished, overrun,
         cmd_count} !== '0) begin
      errs++; $display("FAIL reset_main: outputs=%h required 0", {bus.rom_addr, bus.data_out,
        bus.next_out, bus.done_out, busy, finished, overrun, cmd_count});
    end
    vecs++;
    if ({bus_s.rom_addr, bus_s.data_out, bus_s.next_out, bus_s.done_out, busy_s, finished_s,
         overrun_s, cmd_count_s} !== '0) begin
      errs++; $display("FAIL reset_small: outputs nonzero, required 0");
    end
    @(negedge clock); reset = 1'b0; mdata = '0;
  endtask

  task automatic test_timing();
    logic [5:0] dt [13];
    logic nx [13], bz [13], fn [13];
    int ecyc, ecmd; bit efin, eovr;
    rom[0] = 8'h03; rom[1] = 8'hC0;
    model_main(ecyc, efin, eovr, ecmd);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int k = 0; k < 13; k++) begin
      dt[k] = bus.data_out; nx[k] = bus.next_out; bz[k] = busy; fn[k] = finished;
      @(negedge clock);
    end
    vecs++; if (dt[1] !== 6'd0) begin errs++; $display("FAIL data_early: %0d required 0", dt[1]); end
    vecs++; if (dt[2] !== 6'd3) begin errs++; $display("FAIL data_latch: %0d required 3", dt[2]); end
    vecs++;
    if ({nx[4], nx[5], nx[6], nx[7]} !== 4'b0110) begin
      errs++; $display("FAIL next_timing: %b required 0110", {nx[4], nx[5], nx[6], nx[7]});
    end
    vecs++;
    if ({bz[10], bz[11], fn[11]} !== 3'b101) begin
      errs++; $display("FAIL end_timing: busy10/busy11/fin11=%b required 101", {bz[10], bz[11], fn[11]});
    end
    vecs++; if (cmd_count !== 8'd1) begin errs++; $display("FAIL timing_cmds: %0d required 1", cmd_count); end
  endtask

  // Fixed {DATA 1, DONE, STEP, STEP, END} first, then random scripts.
  task automatic test_sequence();
    int ecyc, ecmd, cyc, len; bit efin, eovr, to;
    logic [1:0] op;
    for (int it = 0; it < 20; it++) begin
      if (it == 0) begin
        rom[0] = 8'h01; rom[1] = 8'h40; rom[2] = 8'h80; rom[3] = 8'h80; rom[4] = 8'hC0;
      end else begin
        len = $urandom_range(1, 12);
        for (int a = 0; a < len; a++) begin
          op = 2'($urandom_range(0, 2));
          rom[a] = {op, 6'($urandom)};
        end
        rom[len] = {2'b11, 6'($urandom)};
        rom[len+1] = 8'($urandom);
      end
      model_main(ecyc, efin, eovr, ecmd);
      run_main(1'b0, cyc, to);
      vecs++; if (to) begin errs++; $display("FAIL seq_timeout: run %0d busy never dropped", it); end
      vecs++; if (cyc != ecyc) begin errs++; $display("FAIL seq_cycles: run %0d busy %0d cycles required %0d", it, cyc, ecyc); end
      vecs++;
      if ({finished, overrun} !== {efin, eovr}) begin
        errs++; $display("FAIL seq_flags: run %0d fin/ovr=%b%b required %b%b", it, finished, overrun, efin, eovr);
      end
      vecs++; if (cmd_count !== AW'(ecmd)) begin errs++; $display("FAIL seq_cmds: run %0d %0d required %0d", it, cmd_count, ecmd); end
      vecs++;
      if (obs_done.size() != exp_done.size()) begin
        errs++; $display("FAIL seq_pulses: run %0d %0d pulses required %0d", it, obs_done.size(), exp_done.size());
      end
      for (int p = 0; p < obs_done.size() && p < exp_done.size(); p++) begin
        vecs++;
        if (obs_done[p] !== exp_done[p] || obs_data[p] !== exp_data[p] || obs_w[p] != PC) begin
          errs++; $display("FAIL seq_pulse: run %0d pulse %0d done=%0d data=%0d width=%0d required done=%0d data=%0d width=%0d",
                           it, p, obs_done[p], obs_data[p], obs_w[p], exp_done[p], exp_data[p], PC);
        end
      end
    end
  endtask

  task automatic test_start_spam();
    int ecyc, ecmd, cyc; bit efin, eovr, to, drained;
    rom[0] = 8'h05; rom[1] = 8'h80; rom[2] = 8'hC0;
    model_main(ecyc, efin, eovr, ecmd);
    run_main(1'b1, cyc, to);
    vecs++;
    if (to || cyc != ecyc || obs_done.size() != exp_done.size()) begin
      errs++; $display("FAIL spam_run: cycles=%0d pulses=%0d required cycles=%0d pulses=%0d",
                       cyc, obs_done.size(), ecyc, exp_done.size());
    end
    @(negedge clock);
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL spam_stop: busy=%b required 0", busy); end
    @(negedge clock);
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL spam_idle_accept: busy=%b required 1", busy); end
    start = 1'b0; drained = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!busy) begin drained = 1; break; end
    end
    vecs++; if (!drained) begin errs++; $display("FAIL spam_drain: busy stuck at 1, required 0"); end
  endtask

  task automatic test_reset_mid_pulse();
    int ecyc, ecmd, cyc; bit efin, eovr, to, hit;
    rom[0] = 8'h2A; rom[1] = 8'hC0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    hit = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.next_out) begin hit = 1; break; end
      @(negedge clock);
    end
    vecs++; if (!hit) begin errs++; $display("FAIL mid_pulse_seen: next_out never rose, required a pulse"); end
    #1 reset = 1'b1;
    #1;
    vecs++;
    if ({bus.rom_addr, bus.data_out, bus.next_out, bus.done_out, busy, finished, overrun,
         cmd_count} !== '0) begin
      errs++; $display("FAIL mid_pulse_reset: next_out=%b busy=%b data=%0d required all 0",
                       bus.next_out, busy, bus.data_out);
    end
    @(negedge clock); reset = 1'b0; mdata = '0;
    model_main(ecyc, efin, eovr, ecmd);
    run_main(1'b0, cyc, to);
    vecs++;
    if (to || obs_data.size() != 1 || cyc != ecyc) begin
      errs++; $display("FAIL restart_after_reset: pulses=%0d cycles=%0d required 1 and %0d", obs_data.size(), cyc, ecyc);
    end else if (obs_data[0] !== 6'h2A) begin
      errs++; $display("FAIL restart_after_reset: data=%0d required 42", obs_data[0]);
    end
  endtask

  task automatic test_overrun();
    int pulses, cyc; bit pn, done;
    for (int a = 0; a < 8; a++) rom_s[a] = {2'b00, 6'($urandom)};
    @(negedge clock); start_s = 1'b1;
    @(negedge clock); start_s = 1'b0;
    pulses = 0; cyc = 0; pn = 0; done = 0;
    for (int i = 0; i < 400; i++) begin
      if (bus_s.next_out && !pn) pulses++;
      pn = bus_s.next_out;
      if (!busy_s) begin done = 1; break; end
      cyc++;
      @(negedge clock);
    end
    vecs++; if (!done || pulses != 8) begin errs++; $display("FAIL ovr_pulses: %0d required 8", pulses); end
    vecs++; if (cyc != 8 * (2 + SC + PC + GC)) begin errs++; $display("FAIL ovr_cycles: %0d required %0d", cyc, 8 * (2 + SC + PC + GC)); end
    vecs++;
    if ({overrun_s, finished_s, busy_s} !== 3'b100) begin
      errs++; $display("FAIL ovr_flags: ovr/fin/busy=%b required 100", {overrun_s, finished_s, busy_s});
    end
    vecs++; if (cmd_count_s !== 3'd0) begin errs++; $display("FAIL ovr_cmds: %0d required 0", cmd_count_s); end
    vecs++; if (bus_s.data_out !== rom_s[7][5:0]) begin errs++; $display("FAIL ovr_data: %0d required %0d", bus_s.data_out, rom_s[7][5:0]); end
  endtask

`ifdef TM_FEED_HALT_EN
  task automatic test_halt();
    int pulses; bit pn, done;
    rom[0] = 8'h80; rom[1] = 8'h80; rom[2] = 8'h80; rom[3] = 8'hC0;
    compute_done = 1'b0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    pulses = 0; pn = 0; done = 0;
    for (int i = 0; i < 400; i++) begin
      if (bus.next_out && !pn) pulses++;
      if (!bus.next_out && pn) compute_done = 1'b1;
      pn = bus.next_out;
      if (!busy) begin done = 1; break; end
      @(negedge clock);
    end
    vecs++; if (!done || pulses != 1) begin errs++; $display("FAIL halt_pulses: %0d required 1", pulses); end
    vecs++;
    if ({finished, overrun} !== 2'b10 || bus.rom_addr !== 8'd1 || cmd_count !== 8'd1) begin
      errs++; $display("FAIL halt_state: fin=%b ovr=%b addr=%0d cmds=%0d required 1 0 1 1",
                       finished, overrun, bus.rom_addr, cmd_count);
    end
    compute_done = 1'b0;
    @(negedge clock);
  endtask
`endif

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = 8'hC0;
    for (int a = 0; a < 8; a++) rom_s[a] = 8'h00;
    test_reset();
    test_timing();
    test_sequence();
    test_start_spam();
    test_reset_mid_pulse();
    test_overrun();
`ifdef TM_FEED_HALT_EN
    test_halt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
